// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
// Round-robin arbiter for four SRAM clients (sym, bus, node, mc) in front of
// sram_control. A winner owns the SRAM for a fixed window of ACCESS_CYCLES
// cycles. One empty turnaround cycle follows, which carries the done pulse
// and any captured read data.
//
// Handshake: a client raises its req and keeps it high until it sees its
// grant bit. Requests are sampled only while the arbiter is idle. Once a
// grant has been issued it runs for the full window even if the req drops.
// The done pulse in the turnaround cycle is the client's completion strobe.
module sram_req_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_req,
    input  logic       bus_req,
    input  logic       node_req,
    input  logic       mc_req,
    input  logic       sram_read,
    input  logic [7:0] read_data,
    output logic [2:0] state,
    output logic [3:0] grant,
    output logic [3:0] done,
    output logic [7:0] rdata,
    output logic       rdata_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } fsm_t;

    // The counter reload value is the window length minus one. The last
    // grant cycle is the one in which the counter reads zero.
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    // Client index encoding: 0 sym, 1 bus, 2 node, 3 mc.
    localparam logic [1:0] CLIENT_MC = 2'd3;

    fsm_t       fsm_q, fsm_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rdata_valid_q, rdata_valid_d;

    logic [3:0] req_vec;
    logic [1:0] cand;
    logic [1:0] win_idx;
    logic       win_found;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    function automatic logic [2:0] client_code(input logic [1:0] idx);
        client_code = {1'b0, idx} + 3'd1;
    endfunction

    // Round-robin search. It starts at the client after the last one served
    // and wraps sym -> bus -> node -> mc -> sym.
    always_comb begin
        req_vec   = {mc_req, node_req, bus_req, sym_req};
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!win_found && req_vec[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic and registered-output values for the IDLE/ACCESS/TURN cycle.
    always_comb begin
        fsm_d         = fsm_q;
        owner_d       = owner_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        state_d       = 3'b000;
        grant_d       = 4'b0000;
        done_d        = 4'b0000;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (win_found) begin
                    fsm_d   = ACCESS;
                    owner_d = win_idx;
                    last_d  = win_idx;
                    cnt_d   = CNT_LOAD;
                    state_d = client_code(win_idx);
                    grant_d = onehot(win_idx);
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // This is the final grant cycle. Release the SRAM, flag
                    // completion, and take read data if this was a read.
                    fsm_d  = TURN;
                    done_d = onehot(owner_q);
                    if (sram_read) begin
                        rdata_d       = read_data;
                        rdata_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = client_code(owner_q);
                    grant_d = onehot(owner_q);
                end
            end
            TURN: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears them at once, even in the
    // middle of an access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q         <= IDLE;
            owner_q       <= 2'd0;
            last_q        <= CLIENT_MC;
            cnt_q         <= 4'd0;
            state_q       <= 3'b000;
            grant_q       <= 4'b0000;
            done_q        <= 4'b0000;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign state       = state_q;
    assign grant       = grant_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter. A timeline reference model tracks which
// client owns the SRAM and when its window started. Expected outputs follow
// from the cycle offset within that window.
module tb_sram_req_arbiter;

    localparam int A = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_req = 1'b0, bus_req = 1'b0, node_req = 1'b0, mc_req = 1'b0;
    logic       sram_read = 1'b0;
    logic [7:0] read_data = 8'h00;
    logic [2:0] state;
    logic [3:0] grant;
    logic [3:0] done;
    logic [7:0] rdata;
    logic       rdata_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         cyc     = 0;
    int         start   = -1;
    int         own     = 0;
    int         last    = 3;
    logic [7:0] m_rdata = 8'h00;
    logic       m_rv    = 1'b0;

    sram_req_arbiter #(.ACCESS_CYCLES(A)) dut (
        .clk(clk), .rst(rst),
        .sym_req(sym_req), .bus_req(bus_req), .node_req(node_req), .mc_req(mc_req),
        .sram_read(sram_read), .read_data(read_data),
        .state(state), .grant(grant), .done(done),
        .rdata(rdata), .rdata_valid(rdata_valid)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one clock. The model decides on the inputs of the current
    // cycle, and then all outputs of the next cycle are compared.
    task automatic step();
        logic [3:0] req;
        logic [3:0] eg, ed;
        logic [2:0] es;
        bit         idle_now;
        int         k;
        req      = {mc_req, node_req, bus_req, sym_req};
        idle_now = (start < 0) || (cyc - start >= A + 2);
        if (idle_now && req != 4'b0) begin
            for (int i = 1; i <= 4; i++) begin
                int idx;
                idx = (last + i) % 4;
                if (req[idx]) begin
                    start = cyc;
                    own   = idx;
                    last  = idx;
                    break;
                end
            end
        end
        m_rv = 1'b0;
        if (start >= 0 && cyc == start + A && sram_read) begin
            m_rv    = 1'b1;
            m_rdata = read_data;
        end
        @(posedge clk);
        #1;
        cyc++;
        eg = 4'b0;
        ed = 4'b0;
        es = 3'b0;
        if (start >= 0) begin
            k = cyc - start;
            if (k >= 1 && k <= A) begin
                eg = 4'b0001 << own;
                es = 3'(own + 1);
            end
            if (k == A + 1) ed = 4'b0001 << own;
        end
        chk("state", 32'(state), 32'(es));
        chk("grant", 32'(grant), 32'(eg));
        chk("done", 32'(done), 32'(ed));
        chk("rdata", 32'(rdata), 32'(m_rdata));
        chk("rdata_valid", 32'(rdata_valid), 32'(m_rv));
        chk("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
        chk("grant_done_excl", 32'((grant != 4'b0) && (done != 4'b0)), 32'd0);
    endtask

    // Assert reset between clock edges. Outputs must clear immediately.
    task automatic reset_now();
        rst = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_rvalid", 32'(rdata_valid), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        cyc++;
        start   = -1;
        last    = 3;
        m_rdata = 8'h00;
        m_rv    = 1'b0;
    endtask

    task automatic set_reqs(input logic [3:0] r);
        {mc_req, node_req, bus_req, sym_req} = r;
    endtask

    initial begin
        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        chk("por_state", 32'(state), 32'd0);
        chk("por_grant", 32'(grant), 32'd0);
        chk("por_done", 32'(done), 32'd0);
        chk("por_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;

        // Single sym request for one idle cycle.
        set_reqs(4'b0001);
        step();
        chk("t1_state_g1", 32'(state), 32'd1);
        set_reqs(4'b0000);
        step();
        chk("t1_grant_g2", 32'(grant), 32'h1);
        step();
        chk("t1_done", 32'(done), 32'h1);
        step();
        chk("t1_idle", 32'(state), 32'd0);

        // All four requesting continuously, starting from reset priority.
        reset_now();
        set_reqs(4'b1111);
        step();
        chk("t2_first_sym", 32'(grant), 32'h1);
        repeat (4) step();
        chk("t2_second_bus", 32'(state), 32'd2);
        repeat (4) step();
        chk("t2_third_node", 32'(state), 32'd3);
        repeat (4) step();
        chk("t2_fourth_mc", 32'(state), 32'd4);
        repeat (4) step();
        chk("t2_fifth_sym", 32'(grant), 32'h1);
        set_reqs(4'b0000);
        repeat (4) step();

        // Wrap priority: after mc, sym beats node.
        set_reqs(4'b1000);
        step();
        set_reqs(4'b0000);
        repeat (3) step();
        set_reqs(4'b0101);
        step();
        chk("t3_wrap_sym", 32'(grant), 32'h1);
        set_reqs(4'b0000);
        repeat (3) step();

        // Read capture on mc, then a bus write leaves rdata alone.
        set_reqs(4'b1000);
        step();
        set_reqs(4'b0000);
        step();
        sram_read = 1'b1;
        read_data = 8'hA5;
        step();
        chk("t4_rdata", 32'(rdata), 32'hA5);
        chk("t4_rvalid", 32'(rdata_valid), 32'd1);
        sram_read = 1'b0;
        step();
        chk("t4_rvalid_pulse", 32'(rdata_valid), 32'd0);
        set_reqs(4'b0010);
        step();
        set_reqs(4'b0000);
        step();
        read_data = 8'h3C;
        step();
        chk("t4_write_rdata", 32'(rdata), 32'hA5);
        chk("t4_write_rvalid", 32'(rdata_valid), 32'd0);
        step();

        // Early drop of node_req.
        set_reqs(4'b0100);
        step();
        set_reqs(4'b0000);
        step();
        chk("t5_held", 32'(grant), 32'h4);
        step();
        chk("t5_done", 32'(done), 32'h4);
        step();

        // Reset in the middle of a bus grant.
        set_reqs(4'b0010);
        step();
        chk("t6_bus_granted", 32'(grant), 32'h2);
        reset_now();
        set_reqs(4'b0011);
        step();
        chk("t6_sym_first", 32'(grant), 32'h1);
        set_reqs(4'b0000);
        repeat (3) step();

        // Random traffic, with an occasional reset.
        repeat (400) begin
            set_reqs(4'($urandom_range(0, 15)));
            sram_read = 1'($urandom_range(0, 1));
            read_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 63) == 0) reset_now();
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Round-robin arbiter in front of `sram_control` for the sym, bus, node and mc requesters. It drives the 3-bit `state` select into `sram_control` and returns a one-hot grant to each client. It holds each grant for a fixed access window, inserts a turnaround cycle between owners, and captures SRAM read data for the owning client.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 2: cycles a grant is held. Legal range 1..15.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `sym_req`  in  1  sym requester wants SRAM
- `bus_req`  in  1  bus requester wants SRAM
- `node_req`  in  1  node requester wants SRAM
- `mc_req`  in  1  mc requester wants SRAM
- `sram_read`  in  1  read strobe as driven by `sram_control` to the SRAM
- `read_data`  in  8  SRAM read data
- `state`  out  3  select to `sram_control`: 000 none, 001 sym, 010 bus, 011 node, 100 mc
- `grant`  out  4  one-hot grant: [0] sym, [1] bus, [2] node, [3] mc
- `done`  out  4  one-cycle pulse, one-hot, marks the end of the owner's access
- `rdata`  out  8  captured read data, held until the next capture
- `rdata_valid`  out  1  one-cycle pulse when `rdata` is updated

## Operation
- FSM states are IDLE, ACCESS and TURN.
- IDLE:
  - `state`=000, `grant`=0.
  - If any req is high, select the winner combinationally and go to ACCESS at the next edge.
  - The winner is loaded into the `owner` register, and the counter is loaded with ACCESS_CYCLES-1.
- ACCESS:
  - `state` is the owner code and `grant` is the owner one-hot; both are registered and stable for exactly ACCESS_CYCLES cycles.
  - The counter is 4 bits and decrements each cycle.
  - At the edge where the counter equals 0, go to TURN.
- TURN:
  - `state`=000, `grant`=0 for one cycle, so two clients never drive `sram_control` on back-to-back cycles.
  - Always returns to IDLE.
- Round-robin:
  - The `last` register holds the most recently served client.
  - The search order starts at `last`+1 and wraps mod 4, in the order sym→bus→node→mc→sym.
  - `last` is updated when ACCESS is entered.
- Committed access:
  - Deasserting req during ACCESS does not shorten the grant; `done` still pulses.
  - req is only sampled in IDLE.
- Read capture:
  - On the edge leaving ACCESS, if `sram_read`=1, load `read_data` into `rdata` and set `rdata_valid`=1 for the TURN cycle.
  - If the access is a write, `rdata` is unchanged and `rdata_valid`=0.
- `done`:
  - Registered on the same edge that leaves ACCESS.
  - Equals the owner one-hot during the TURN cycle, 0 otherwise.
- Reset:
  - Asserting `rst` at any time, including mid-ACCESS, forces the FSM to IDLE immediately, with no `done` pulse.
  - Reset values: `state`=000, `grant`=0000, `done`=0000, `rdata`=00, `rdata_valid`=0, counter=0.
  - `last`=mc, so sym has first priority after reset.
- Invariants:
  - `grant` is never multi-hot.
  - `state`≠000 if and only if the FSM is in ACCESS.
  - `grant` and `done` are never both nonzero in the same cycle.

## Timing
- Request to grant: a req high in IDLE cycle n gives `grant`/`state` asserted in cycles n+1 … n+ACCESS_CYCLES.
- TURN is cycle n+ACCESS_CYCLES+1 and carries `done`/`rdata_valid`; IDLE is n+ACCESS_CYCLES+2.
- Continuous requests give one grant every ACCESS_CYCLES+2 cycles (4 cycles at the default).
- ACCESS_CYCLES=1: a single-cycle grant with the same TURN/IDLE spacing.
- `read_data` is sampled only on the final ACCESS edge. The SRAM must present data by the end of the last grant cycle.
- Reset is asynchronous: outputs clear within the same timestep as the `rst` rising edge, not at the next clock.

## Test plan
- Single request, default params: `sym_req`=1 for one IDLE cycle after reset → `state`=001 and `grant`=0001 for 2 cycles, then `done`=0001 for 1 cycle, then `state`=000.
- All four requesting continuously → grant order sym, bus, node, mc, sym. Each grant lasts 2 cycles and successive grants are 4 cycles apart. `state` sequence is 001, 010, 011, 100, 001.
- Wrap priority: mc served last while sym and node both request → sym granted next, not node.
- Read capture: mc granted, `sram_read`=1, `read_data`=8'hA5 on the final grant cycle → `rdata`=A5 with `rdata_valid`=1 for one cycle. A following bus write with `read_data`=3C leaves `rdata`=A5 and `rdata_valid`=0.
- Early drop: `node_req` deasserted in the first grant cycle → grant is still held 2 cycles and `done`=0100 still pulses.
- Reset mid-access: assert `rst` in the middle of a bus grant → `state`=000, `grant`=0 and `done`=0 immediately. After release, with bus and sym requesting, sym is served first.
